// File: rtl/compute_unit_sequencer.sv
// rtl/compute_unit_sequencer.sv - program buffer and issue controller for the 16-bit compute unit
module compute_unit_sequencer #(
   parameter int DEPTH        = 16,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  cfg_data,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic        start,
   input  logic        clear,
   output logic [15:0] issue_instr,
   output logic        issue_en,
   input  logic        res_valid,
   input  logic [7:0]  res_data,
   input  logic [3:0]  res_reg_id,
   output logic        busy,
   output logic        done,
   output logic [4:0]  prog_len,
   output logic [4:0]  result_count,
   output logic [7:0]  last_result,
   output logic [3:0]  last_reg
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [4:0] DEPTH_L = 5'(DEPTH);
   localparam logic [7:0] DRAIN_L = 8'(DRAIN_CYCLES);

   logic [1:0]  state;
   logic        phase;
   logic [7:0]  low_byte;
   logic [4:0]  pc;
   logic [7:0]  drain_cnt;
   logic [15:0] mem [DEPTH];

   logic        start_go;
   logic        byte_go;
   logic [15:0] cur_word;
   logic        cur_halt;
   logic        last_slot;

   // Handshake, start qualification and the word currently addressed by pc.
   always_comb begin
      cfg_ready = (state == S_IDLE) && (prog_len < DEPTH_L);
      start_go  = start && !clear &&
                  (((state == S_IDLE) && (prog_len != 5'd0)) || (state == S_DONE));
      // A start on the same edge wins over a byte; clear wins over both.
      byte_go   = cfg_valid && cfg_ready && !clear && !start_go;
      cur_word  = mem[pc[AW-1:0]];
      cur_halt  = (cur_word[15:12] == 4'b1111);
      last_slot = (pc == (prog_len - 5'd1));
      busy      = (state == S_RUN) || (state == S_DRAIN);
      done      = (state == S_DONE);
   end

   // Program storage; a word is committed when its high byte is accepted.
   always_ff @(posedge clk) begin
      if (byte_go && phase) begin
         mem[prog_len[AW-1:0]] <= {cfg_data, low_byte};
      end
   end

   // Sequencer: loading, issue, drain and completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         prog_len    <= 5'd0;
         phase       <= 1'b0;
         low_byte    <= 8'd0;
         pc          <= 5'd0;
         drain_cnt   <= 8'd0;
         issue_en    <= 1'b0;
         issue_instr <= 16'd0;
      end else if (clear) begin
         state       <= S_IDLE;
         prog_len    <= 5'd0;
         phase       <= 1'b0;
         pc          <= 5'd0;
         drain_cnt   <= 8'd0;
         issue_en    <= 1'b0;
         issue_instr <= 16'd0;
      end else if (start_go) begin
         state     <= S_RUN;
         phase     <= 1'b0;
         pc        <= 5'd0;
         drain_cnt <= 8'd0;
         issue_en  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (byte_go) begin
                  if (!phase) begin
                     low_byte <= cfg_data;
                     phase    <= 1'b1;
                  end else begin
                     phase    <= 1'b0;
                     prog_len <= prog_len + 5'd1;
                  end
               end
            end
            S_RUN: begin
               if (cur_halt) begin
                  issue_en    <= 1'b0;
                  issue_instr <= 16'd0;
                  drain_cnt   <= 8'd0;
                  state       <= S_DRAIN;
               end else begin
                  issue_en    <= 1'b1;
                  issue_instr <= cur_word;
                  pc          <= pc + 5'd1;
                  if (last_slot) begin
                     drain_cnt <= 8'd0;
                     state     <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               issue_en    <= 1'b0;
               issue_instr <= 16'd0;
               if (drain_cnt == DRAIN_L) begin
                  state <= S_DONE;
               end else begin
                  drain_cnt <= drain_cnt + 8'd1;
               end
            end
            default: begin
               issue_en <= 1'b0;
            end
         endcase
      end
   end

   // Result capture from the compute unit; a start clears it, clear keeps it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_count <= 5'd0;
         last_result  <= 8'd0;
         last_reg     <= 4'd0;
      end else if (start_go) begin
         result_count <= 5'd0;
         last_result  <= 8'd0;
         last_reg     <= 4'd0;
      end else if (res_valid) begin
         last_result <= res_data;
         last_reg    <= res_reg_id;
         if (result_count != 5'd31) begin
            result_count <= result_count + 5'd1;
         end
      end
   end

endmodule

// File: doc/compute_unit_sequencer.md
# compute_unit_sequencer

Program buffer and issue controller for the 16-bit-instruction compute unit. It accepts a program as a byte stream over an 8-bit handshake, stores up to DEPTH instructions, then issues them back-to-back to the compute unit's `instruction`/`ena` inputs. It also captures the unit's result stream (`data_valid`/`data`/`reg_id`) into status registers. It sits between the chip's pin-level I/O and the compute unit.

## Interface
Parameters:
- DEPTH, 16, number of instruction slots; must be a power of two, at most 16.
- DRAIN_CYCLES, 2, number of cycles spent in DRAIN after the last issue, waiting for the unit's registered results.

Ports:
- clk  in  1  single clock; everything updates on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- cfg_data  in  8  program byte.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  a byte is accepted on an edge where cfg_valid && cfg_ready.
- start  in  1  pulse that runs the stored program.
- clear  in  1  pulse that aborts any run and erases the program.
- issue_instr  out  16  instruction to the compute unit; registered.
- issue_en  out  1  enable to the compute unit; registered.
- res_valid  in  1  compute unit data_valid.
- res_data  in  8  compute unit data.
- res_reg_id  in  4  compute unit reg_id.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- prog_len  out  5  number of stored instructions, 0..DEPTH.
- result_count  out  5  results seen since the last start; saturates at 31.
- last_result  out  8  res_data of the most recent result.
- last_reg  out  4  res_reg_id of the most recent result.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- cfg_ready is combinational: (state==IDLE) && (prog_len<DEPTH).
- Loading, IDLE only:
  - Bytes arrive low byte first, then high byte; a 1-bit phase flag tracks which.
  - When a high byte is accepted, {high,low} is written to mem[prog_len] and prog_len increments.
  - When prog_len reaches DEPTH, the buffer is full: cfg_ready=0 and bytes are not accepted.
- start in IDLE with prog_len>0, or in DONE:
  - Clear the phase flag; a pending low byte is discarded.
  - Clear result_count, last_result and last_reg.
  - pc=0; enter RUN.
- start in IDLE with prog_len==0 is ignored.
- RUN, each cycle:
  - If mem[pc][15:12]==4'b1111 (HALT): the word is not issued; issue_en=0; enter DRAIN.
  - Otherwise issue_instr=mem[pc], issue_en=1, pc++.
  - After the word at index prog_len-1 has issued, the next cycle has issue_en=0 and the state is DRAIN.
  - Opcodes 0000–1110 are all issued unchanged (NOP included).
- DRAIN: issue_en=0, issue_instr=0; count DRAIN_CYCLES cycles, then enter DONE.
- DONE: done=1. The program is kept; start reruns it from index 0.
- clear, any state:
  - Next edge: state IDLE, prog_len=0, phase=0, pc=0, issue_en=0, issue_instr=0.
  - Result registers are kept.
  - clear has priority over start and over a byte accepted on the same edge.
- Result capture, in every state: on each edge with res_valid=1:
  - last_result<=res_data, last_reg<=res_reg_id.
  - result_count increments, saturating at 31.
  - On a start edge, the clear of the result registers wins over a simultaneous res_valid.
- cfg_valid, start and clear are ignored where not listed above; in RUN/DRAIN, cfg_ready=0.
- The memory is not reset. Contents beyond prog_len are don't-care and are never issued.

## Timing
- Reset values: state=IDLE, prog_len=0, phase=0, pc=0, issue_en=0, issue_instr=0, busy=0, done=0, result_count=0, last_result=0, last_reg=0, cfg_ready=1.
- Reset assertion mid-run forces these values immediately, without waiting for a clock.
- Start latency: start sampled at edge E0 → state RUN after E0. The first issue_en=1 is visible after E1 and is sampled by the compute unit at E2.
- Throughput: one instruction per cycle, no gaps. N instructions give exactly N consecutive issue_en=1 cycles.
- HALT at index h: exactly h issue cycles. A HALT at index 0 gives zero issues.
- done rises DRAIN_CYCLES+1 cycles after the last issue_en=1 cycle.
- A compute-unit result for the last instruction is captured before done=1.
- Byte load: 2 accepted bytes per instruction; prog_len updates on the edge that accepts the high byte.

## Test plan
- Reset, then load bytes 05,11 / 03,12 / 21,23, then pulse start:
  - prog_len=3.
  - issue_instr sequence 1105, 1203, 2321 on 3 consecutive cycles.
  - done=1 after DRAIN.
  - With the unit attached: result_count=3, last_reg=3, last_result=8.
- Load the words 1101, F000, 1202, then start: exactly one issue (1101); result_count=1; done=1.
- Load 16 words: cfg_ready=0 afterwards and a 17th byte is not accepted. Run: 16 consecutive issue_en cycles.
- Pulse clear in the middle of a 16-word run: issue_en=0 the next cycle, state IDLE, prog_len=0, cfg_ready=1.
- Pulse start in DONE twice: the identical issue sequence repeats, and result_count restarts from 0 each run.
- Drive rst_n low between clock edges during RUN: issue_en and busy drop to 0 immediately. Load one low byte only, then start with prog_len>0: the pending byte is dropped and phase=0.
